// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: response owner, arbiter state,
// round-robin history and lock counter sizing.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef enum logic {
    LAST_CORE = 1'b0,
    LAST_DMA  = 1'b1
  } last_e;

  function automatic int lock_cnt_width(input int max_lock);
    return $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a shared single-port data memory: round-robin between
// core and DMA, bounded DMA burst lock, and read-response routing.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LOCK_W = lock_cnt_width(MAX_LOCK);

  state_e            state_q, state_d;
  last_e             last_q, last_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  owner_e            rsp_owner_q, rsp_owner_d;
  logic              lock_max;

  assign lock_max = (lock_cnt_q == LOCK_W'(MAX_LOCK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      last_q      <= LAST_DMA;
      lock_cnt_q  <= '0;
      rsp_owner_q <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lock_cnt_d  = lock_cnt_q;
    rsp_owner_d = OWN_NONE;
    if (c_gnt) begin
      last_d = LAST_CORE;
      if (!c_we) rsp_owner_d = OWN_CORE;
    end
    if (d_gnt) begin
      last_d = LAST_DMA;
      if (!d_we) rsp_owner_d = OWN_DMA;
    end
    case (state_q)
      ST_ARB: begin
        if (d_gnt && d_lock) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = LOCK_W'(1);
        end
      end
      default: begin
        // Staying locked needs a granted DMA cycle that asks to keep the lock.
        if (d_gnt && d_lock) begin
          if (!lock_max) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    // Grants are gated by rst_n so nothing reaches the memory while in reset.
    if (rst_n) begin
      if (state_q == ST_LOCKED) begin
        if (lock_max && c_req) c_gnt = 1'b1;
        else if (d_req)        d_gnt = 1'b1;
        else if (c_req)        c_gnt = 1'b1;
      end else if (c_req && d_req) begin
        c_gnt = (last_q == LAST_DMA);
        d_gnt = (last_q == LAST_CORE);
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end

    mem_en    = c_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end

    c_rvalid = (rsp_owner_q == OWN_CORE);
    d_rvalid = (rsp_owner_q == OWN_DMA);
    c_rdata  = c_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected per-cycle activity
// into a queue, a negedge monitor pops and compares whenever the DUT is active.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic          cg;
    logic          dg;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          cv;
    logic [DW-1:0] cd;
    logic          dv;
    logic [DW-1:0] dd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("gnt_exclusive", 32'(c_gnt & d_gnt), 32'd0);
      if (c_gnt || d_gnt || c_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_activity", {28'd0, c_gnt, d_gnt, c_rvalid, d_rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("c_gnt", 32'(c_gnt), 32'(e.cg));
          chk("d_gnt", 32'(d_gnt), 32'(e.dg));
          chk("mem_en", 32'(mem_en), 32'(e.cg | e.dg));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("c_rvalid", 32'(c_rvalid), 32'(e.cv));
          chk("c_rdata", c_rdata, e.cd);
          chk("d_rvalid", 32'(d_rvalid), 32'(e.dv));
          chk("d_rdata", d_rdata, e.dd);
        end
      end
    end
  end

  task automatic expect_cyc(input logic cg, input logic dg, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic cv, input logic [DW-1:0] cd,
                            input logic dv, input logic [DW-1:0] dd);
    exp_t e;
    e.cg = cg; e.dg = dg; e.we = we; e.addr = addr; e.wdata = wdata;
    e.cv = cv; e.cd = cd; e.dv = dv; e.dd = dd;
    exp_q.push_back(e);
  endtask

  task automatic core(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic dma(input logic req, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req = req; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
  endtask

  task automatic idle();
    core(1'b0, 1'b0, '0, '0);
    dma(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"},
        {23'd0, c_gnt, c_rvalid, d_gnt, d_rvalid, mem_en, mem_we, 3'd0}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, c_rdata | d_rdata, 32'd0);
  endtask

  initial begin
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h8]  = 32'hAAAA0008;
    mem[32'hC]  = 32'hBBBB000C;

    // Reset with both ports requesting: every output must stay low.
    core(1'b1, 1'b0, 32'h10, 32'h0);
    dma(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    tick(); tick();
    check_all_zero("reset");
    idle();
    rst_n = 1'b1;
    tick();

    // Contention from reset: core first, then alternate.
    core(1'b1, 1'b1, 32'h100, 32'h1);
    dma(1'b1, 1'b1, 1'b0, 32'h200, 32'h2);
    expect_cyc(1, 0, 1, 32'h100, 32'h1, 0, 0, 0, 0); tick();
    expect_cyc(0, 1, 1, 32'h200, 32'h2, 0, 0, 0, 0); tick();
    expect_cyc(1, 0, 1, 32'h100, 32'h1, 0, 0, 0, 0); tick();
    expect_cyc(0, 1, 1, 32'h200, 32'h2, 0, 0, 0, 0); tick();
    idle(); tick();

    // Core-only read.
    core(1'b1, 1'b0, 32'h10, 32'h0);
    expect_cyc(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 0); tick();
    idle();
    expect_cyc(0, 0, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0, 0); tick();

    // Burst lock, MAX_LOCK=3, core requesting throughout (last = core here).
    core(1'b1, 1'b1, 32'h104, 32'h55);
    for (int i = 0; i < 5; i++) begin
      dma(1'b1, 1'b1, 1'b1, 32'h300 + 32'(i), 32'h30 + 32'(i));
      if (i == 3) expect_cyc(1, 0, 1, 32'h104, 32'h55, 0, 0, 0, 0);
      else        expect_cyc(0, 1, 1, 32'h300 + 32'(i), 32'h30 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    idle(); tick();

    // DMA write, then core read of the same word.
    dma(1'b1, 1'b1, 1'b0, 32'h40, 32'h1234);
    expect_cyc(0, 1, 1, 32'h40, 32'h1234, 0, 0, 0, 0); tick();
    idle();
    core(1'b1, 1'b0, 32'h40, 32'h0);
    expect_cyc(1, 0, 0, 32'h40, 32'h0, 0, 0, 0, 0); tick();
    idle();
    expect_cyc(0, 0, 0, 32'h0, 32'h0, 1, 32'h1234, 0, 0); tick();

    // Interleaved reads: DMA then core, responses in consecutive cycles.
    dma(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    expect_cyc(0, 1, 0, 32'h8, 32'h0, 0, 0, 0, 0); tick();
    idle();
    core(1'b1, 1'b0, 32'hC, 32'h0);
    expect_cyc(1, 0, 0, 32'hC, 32'h0, 0, 0, 1, 32'hAAAA0008); tick();
    idle();
    expect_cyc(0, 0, 0, 32'h0, 32'h0, 1, 32'hBBBB000C, 0, 0); tick();

    // Reset in the cycle after a granted read; last was core before reset.
    core(1'b1, 1'b0, 32'h10, 32'h0);
    expect_cyc(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 0); tick();
    dma(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick(); tick();
    idle();
    rst_n = 1'b1;
    tick(); tick();
    core(1'b1, 1'b1, 32'h108, 32'h77);
    dma(1'b1, 1'b1, 1'b0, 32'h208, 32'h88);
    expect_cyc(1, 0, 1, 32'h108, 32'h77, 0, 0, 0, 0); tick();
    idle(); tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one shared single-port data memory between the core load/store path and a DMA/loader port.
- Sits between the processor's ALU-result/store-data path and the data memory. Memory writes are synchronous; read data is registered with 1-cycle latency.
- Provides round-robin fairness, a bounded DMA lock for bursts, and read-response routing back to the owning requester.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_LOCK, 8, maximum consecutive locked DMA grants before the core is forced one grant (range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- c_req  input  1  core access request
- c_we  input  1  core write enable (1 = store, 0 = load)
- c_addr  input  ADDR_W  core byte address
- c_wdata  input  DATA_W  core store data
- c_gnt  output  1  core granted this cycle (combinational)
- c_rvalid  output  1  core read data valid
- c_rdata  output  DATA_W  core read data
- d_req  input  1  DMA request
- d_we  input  1  DMA write enable
- d_lock  input  1  DMA requests to keep the grant next cycle
- d_addr  input  ADDR_W  DMA address
- d_wdata  input  DATA_W  DMA write data
- d_gnt  output  1  DMA granted this cycle
- d_rvalid  output  1  DMA read data valid
- d_rdata  output  DATA_W  DMA read data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after a read strobe

Behaviour:
- Reset (asynchronous on rst_n low):
  - state = ARB, last = DMA (so the core wins the first contention), lock_cnt = 0, rsp_owner = NONE.
  - Every output is 0 during reset.
- Grant rules:
  - Grant is combinational from req and registered state.
  - c_gnt and d_gnt are never both 1.
  - A grant is never issued without the corresponding req.
- ARB state:
  - Only one port requesting: that port is granted.
  - Both ports requesting: grant the port that is not "last".
  - On any grant, "last" updates to the granted port at the clock edge.
- Transition ARB -> LOCKED: DMA granted with d_lock = 1. lock_cnt is then set to 1.
- LOCKED state:
  - d_req = 1: DMA is granted regardless of c_req, and lock_cnt increments.
  - Exit to ARB at the edge when d_req = 0, or when a granted cycle has d_lock = 0.
  - Forced exit: if lock_cnt = MAX_LOCK and c_req = 1, the core is granted that cycle instead, state returns to ARB with last = CORE, and lock_cnt clears. The DMA may relock on its next grant.
  - With lock_cnt = MAX_LOCK and c_req = 0, the DMA is granted without incrementing (saturates).
- Memory drive:
  - mem_en = c_gnt | d_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - With no grant, all are 0.
- Read response:
  - A granted read (we = 0) sets rsp_owner to that port at the edge.
  - In the next cycle the owner's rvalid = 1 and its rdata = mem_rdata. The non-owner's rdata = 0.
  - Writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle, each routed independently.
- Core stalls the pipeline while c_req & ~c_gnt; the arbiter holds no core request internally.
- Reset mid-access: a pending rvalid is dropped and a lock is abandoned.
- Latency: 0 cycles request-to-grant when uncontested; 1 cycle grant-to-rvalid.

Decomposition:
- Shared package:
  - owner encoding OWN_NONE = 2'b00, OWN_CORE = 2'b01, OWN_DMA = 2'b10;
  - state encoding ST_ARB = 1'b0, ST_LOCKED = 1'b1;
  - lock counter width derived from MAX_LOCK (clog2(MAX_LOCK+1)).
- Single module. No sub-module is natural: the grant logic is a 2-way pick, and the lock counter is a few lines.

Test Plan:
- Core-only read: c_req = 1, c_we = 0, c_addr = 0x10, memory returns 0xDEADBEEF.
  - Expected: c_gnt = 1 the same cycle, mem_addr = 0x10, mem_we = 0.
  - Next cycle: c_rvalid = 1, c_rdata = 0xDEADBEEF, d_rvalid = 0.
- Contention from reset: both request for 4 cycles with no lock.
  - Expected grants in order: core, DMA, core, DMA.
  - mem_addr alternates between the two addresses.
- DMA burst lock with MAX_LOCK = 3: DMA granted with d_lock = 1 while the core requests continuously.
  - Expected: DMA, DMA, DMA, then core (forced exit), then DMA (round-robin).
  - c_gnt stays 0 for the first 3 cycles.
- Write then read: DMA writes 0x1234 to 0x40, then the core reads 0x40.
  - Expected: mem_we = 1 and mem_wdata = 0x1234 on the write; no rvalid for the write.
  - c_rvalid = 1 one cycle after the read grant.
- Interleaved reads: DMA read to 0x8, then core read to 0xC in the next cycle.
  - Expected: d_rvalid and c_rvalid pulse in consecutive cycles, each with its own data, never together.
- Reset mid-read: assert rst_n = 0 in the cycle after a granted read.
  - Expected: all outputs 0 immediately and no rvalid after release.
  - After release, the first contention grants the core.
